// File: rtl/slt_sort_sequencer.sv
// slt_sort_sequencer: buffers DEPTH signed words, bubble-sorts them ascending
// with one shared signed less-than per clock, then streams them out.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     input word handshake (accepted in LOAD)
//   out_valid/out_ready/out_data  sorted output handshake, smallest first
//   out_last                      marks the final word of a batch
//   busy                          high while sorting or draining
module slt_sort_sequencer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PMAX = CW'(DEPTH - 2);

  // SETTLE is one cycle between the final compare and the first output
  // word; it counts as part of the busy drain span.
  typedef enum logic [1:0] {
    LOAD,
    SORT,
    SETTLE,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] idx;
  logic [CW-1:0] pass;
  logic          swapped;

  logic [CW-1:0] idx1;
  logic [CW-1:0] idx_end;
  logic          lt;
  logic          acc;
  logic          pass_end;
  logic          sort_done;
  logic          rd_hs;
  logic          rd_last;

  assign idx1    = idx + CW'(1);
  assign idx_end = PMAX - pass;
  assign lt      = $signed(mem[idx1]) < $signed(mem[idx]);
  assign acc     = in_valid && in_ready;
  assign pass_end = !(idx < idx_end);
  // Early exit must see this cycle's compare too, not only earlier swaps.
  assign sort_done = pass_end &&
                     (!(swapped || lt) || pass == PMAX);
  assign rd_hs   = out_valid && out_ready;
  assign rd_last = rd_hs && out_last;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:   if (acc && wr_cnt == LAST) state_nx = SORT;
      SORT:   if (sort_done) state_nx = SETTLE;
      SETTLE: state_nx = DRAIN;
      DRAIN:  if (rd_last) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD) && !rst;
    busy      = (state == SORT) || (state == SETTLE) ||
                (state == DRAIN);
    out_valid = (state == DRAIN);
    out_data  = '0;
    out_last  = 1'b0;
    if (state == DRAIN) begin
      out_data = mem[rd_cnt];
      out_last = (rd_cnt == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (acc) begin
            mem[wr_cnt] <= in_data;
            if (wr_cnt == LAST) begin
              wr_cnt  <= '0;
              pass    <= '0;
              idx     <= '0;
              swapped <= 1'b0;
            end else begin
              wr_cnt <= wr_cnt + CW'(1);
            end
          end
        end
        SORT: begin
          if (lt) begin
            mem[idx]  <= mem[idx1];
            mem[idx1] <= mem[idx];
          end
          if (!pass_end) begin
            idx     <= idx1;
            swapped <= swapped || lt;
          end else if (!sort_done) begin
            pass    <= pass + CW'(1);
            idx     <= '0;
            swapped <= 1'b0;
          end
        end
        DRAIN: begin
          if (rd_hs) begin
            if (rd_last) rd_cnt <= '0;
            else         rd_cnt <= rd_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/slt_sort_sequencer.md
Name: slt_sort_sequencer

Overview:
- Multi-cycle controller that buffers DEPTH signed words, sorts them ascending, and streams them out.
- Uses one shared signed strict-less-than compare per clock.
- Sits beside the ALU compare path as a small accelerator, with valid/ready handshakes on input and output.
- Sorting is a bubble sort sequenced by an FSM with pass and index counters, plus early exit when a pass makes no swap.

Parameters:
DATA_W, 64, operand width in bits; operands are two's-complement signed.
DEPTH, 4, number of words per sort batch; a power of two, at least 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts a word this cycle
in_data  input  DATA_W  signed input word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  DATA_W  sorted word, smallest first
out_last  output  1  high with the final word of a batch
busy  output  1  high in SORT or DRAIN

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - State goes to LOAD; all counters go to 0; buffer entries go to 0.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.
  - Reset mid-operation aborts the batch, discards the buffer, and emits nothing further.
- States:
  - LOAD:
    - in_ready = 1.
    - On in_valid && in_ready, write buf[wr_cnt] and increment wr_cnt.
    - On acceptance of word DEPTH-1, go to SORT with pass = 0, idx = 0, swapped = 0.
  - SORT:
    - in_ready = 0, busy = 1.
    - Each cycle computes lt = signed(buf[idx+1]) < signed(buf[idx]).
    - If lt, swap the two entries at the clock edge and set swapped = 1.
    - Comparison is strict: equal values never swap, so the sort is stable.
    - If idx < DEPTH-2-pass, increment idx.
    - Otherwise the pass ends:
      - If swapped == 0 or pass == DEPTH-2, go to DRAIN.
      - Otherwise increment pass, clear idx and swapped.
    - Compare count is at least DEPTH-1 cycles and at most DEPTH*(DEPTH-1)/2 cycles.
  - DRAIN:
    - out_valid = 1, out_data = buf[rd_cnt], out_last = (rd_cnt == DEPTH-1).
    - On out_valid && out_ready, increment rd_cnt.
    - On the handshake with out_last high, go to LOAD; out_valid = 0 and in_ready = 1 in the next cycle.
    - out_data and out_last hold stable while out_ready is low; no word is skipped or repeated.
- Latency: out_valid first rises N+1 edges after the edge that accepted the last input word, where N is the number of SORT cycles.
- in_valid outside LOAD is ignored and no data is captured.
- Counter widths are clog2(DEPTH), with no wrap beyond DEPTH-1.
- No back-to-back overlap: a new batch is loaded only after the previous drain completes.

Test Plan:
1. Load 10, 20, -10, 5 → output -10, 5, 10, 20; out_last only on 20; 6 SORT cycles; out_valid rises 7 edges after the last accept.
2. Load already sorted -5, -5, 0, 7 → early exit after 3 SORT cycles; out_valid rises 4 edges after the last accept; output -5, -5, 0, 7.
3. Load reverse 7, 3, 0, -9 → output -9, 0, 3, 7; exactly 6 SORT cycles; busy high for the whole SORT plus DRAIN span.
4. Load extremes 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, -1 → output 64'h8000..., -1, 0, 64'h7FFF...
5. Backpressure: hold out_ready low for 3 cycles after the first word is valid, and drive in_valid = 1 throughout DRAIN → out_data stays -10 (case 1 data) while stalled; 4 words are delivered with no loss or duplication; in_ready stays 0 until after out_last.
6. Assert rst for 1 cycle in the 2nd SORT cycle → the next cycle shows busy = 0, out_valid = 0, and in_ready = 1 once rst is low; a fresh batch 3, 1, 2, 0 then outputs 0, 1, 2, 3 with no stale data.
